// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter.
// MEM_ARB_DATA_PRIO_EN selects fixed data priority instead of round-robin.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    RESP  = 2'b10
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic owner_e other(input owner_e o);
    return (o == OWN_DATA) ? OWN_INSTR : OWN_DATA;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus shared by the cache, LSU and main-memory ports.
// The arbiter is the slave of both requesters and the master of memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] read;

  modport master (
    output req, we, be, adr, wdata,
    input  gnt, rvalid, read
  );

  modport slave (
    input  req, we, be, adr, wdata,
    output gnt, rvalid, read
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pointer: favours the requester not served last.
// The pointer comes out of reset favouring data.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   res,
  input  logic   instr_req,
  input  logic   data_req,
  input  logic   done,
  input  owner_e owner,
  output owner_e sel
);

  owner_e ptr;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ptr <= OWN_DATA;
    end else if (done) begin
      ptr <= other(owner);
    end
  end

  always_comb begin
    sel = ptr;
    if (instr_req && !data_req) begin
      sel = OWN_INSTR;
    end else if (data_req && !instr_req) begin
      sel = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache and LSU, one access in flight.
// Define MEM_ARB_DATA_PRIO_EN for fixed data priority (no pointer).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           res,
  mem_arbiter_if.slave  instr,
  mem_arbiter_if.slave  data,
  mem_arbiter_if.master mem
);

  state_e state;
  state_e state_nx;
  owner_e owner;
  owner_e sel;
  logic   any_req;
  logic   own_req;
  logic   is_data;

  logic              arb_req;
  logic              arb_we;
  logic [3:0]        arb_be;
  logic [ADDR_W-1:0] arb_adr;
  logic [DATA_W-1:0] arb_wdata;
  logic              instr_gnt;
  logic              data_gnt;
  logic              instr_rvalid;
  logic              data_rvalid;
  logic [DATA_W-1:0] instr_read;
  logic [DATA_W-1:0] data_read;

  assign any_req = instr.req | data.req;
  assign is_data = (owner == OWN_DATA);
  assign own_req = is_data ? data.req : instr.req;

`ifdef MEM_ARB_DATA_PRIO_EN
  assign sel = data.req ? OWN_DATA : OWN_INSTR;
`else
  logic done;

  assign done = (state == RESP) && mem.rvalid;

  mem_arb_rr u_rr (
    .clk      (clk),
    .res      (res),
    .instr_req(instr.req),
    .data_req (data.req),
    .done     (done),
    .owner    (owner),
    .sel      (sel)
  );
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      owner <= OWN_DATA;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner <= sel;
      end
    end
  end

  // A grant from memory wins over a late drop: the access is already taken.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = GRANT;
      GRANT: begin
        if (mem.gnt) begin
          state_nx = RESP;
        end else if (!own_req) begin
          state_nx = IDLE;
        end
      end
      RESP:    if (mem.rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    arb_req      = 1'b0;
    arb_we       = 1'b0;
    arb_be       = '0;
    arb_adr      = '0;
    arb_wdata    = '0;
    instr_gnt    = 1'b0;
    data_gnt     = 1'b0;
    instr_rvalid = 1'b0;
    data_rvalid  = 1'b0;
    instr_read   = '0;
    data_read    = '0;
    unique case (state)
      GRANT: begin
        arb_req = 1'b1;
        if (is_data) begin
          arb_we    = data.we;
          arb_be    = data.be;
          arb_adr   = data.adr;
          arb_wdata = data.wdata;
          data_gnt  = mem.gnt;
        end else begin
          arb_be    = BE_FULL;
          arb_adr   = instr.adr;
          instr_gnt = mem.gnt;
        end
      end
      RESP: begin
        if (is_data) begin
          data_rvalid = mem.rvalid;
          data_read   = mem.rvalid ? mem.read : '0;
        end else begin
          instr_rvalid = mem.rvalid;
          instr_read   = mem.rvalid ? mem.read : '0;
        end
      end
      default: ;
    endcase
  end

  assign mem.req      = arb_req;
  assign mem.we       = arb_we;
  assign mem.be       = arb_be;
  assign mem.adr      = arb_adr;
  assign mem.wdata    = arb_wdata;
  assign instr.gnt    = instr_gnt;
  assign instr.rvalid = instr_rvalid;
  assign instr.read   = instr_read;
  assign data.gnt     = data_gnt;
  assign data.rvalid  = data_rvalid;
  assign data.read    = data_read;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic
// from both requesters against a behavioural memory and reference store.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] HASH = 32'hA5C3_5A3C;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) db ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .res  (res),
    .instr(ib),
    .data (db),
    .mem  (mb)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  owner_e oq[$];
  bit rd_chk = 1'b0;
  bit own_chk = 1'b0;
  bit mem_auto = 1'b0;
  int gdly_max = 0;
  int rdly_max = 0;
  logic [31:0] store[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_ctrl"}, 64'({mb.req, mb.we, mb.be, ib.gnt, ib.rvalid,
                               db.gnt, db.rvalid}), 64'd0);
    check({tag, "_adr"}, 64'(mb.adr), 64'd0);
    check({tag, "_wdata"}, 64'(mb.wdata), 64'd0);
    check({tag, "_read"}, {ib.read, db.read}, 64'd0);
  endtask

  task automatic apply_reset();
    res = 1'b1;
    #1;
    zero_check("rst");
    step();
    step();
    res = 1'b0;
  endtask

  // Monitor: protocol rules every cycle, responses popped from the queues.
  always @(negedge clk) begin
    if (!res) begin
      check("gnt_excl", 64'(ib.gnt & db.gnt), 64'd0);
      check("rvalid_excl", 64'(ib.rvalid & db.rvalid), 64'd0);
      if (ib.gnt || db.gnt) begin
        check("gnt_src", 64'({mb.req, mb.gnt}), 64'd3);
        if (own_chk) begin
          if (oq.size() == 0) check("owner_extra", 64'(db.gnt), 64'd2);
          else check("owner_order", 64'(db.gnt ? OWN_DATA : OWN_INSTR),
                     64'(oq.pop_front()));
        end
      end
      if (mb.req && mb.gnt) begin
        check("gnt_routed", 64'(ib.gnt | db.gnt), 64'd1);
        if (db.gnt) begin
          check("mem_fields_d", {mb.adr, mb.wdata}, {db.adr, db.wdata});
          check("mem_ctrl_d", 64'({mb.we, mb.be}), 64'({db.we, db.be}));
        end else if (ib.gnt) begin
          check("mem_adr_i", 64'(mb.adr), 64'(ib.adr));
          check("mem_ctrl_i", 64'({mb.we, mb.be}), 64'h0F);
        end
      end
      if (ib.rvalid || db.rvalid) check("rvalid_src", 64'(mb.rvalid), 64'd1);
      if (!ib.rvalid) check("instr_read_idle", 64'(ib.read), 64'd0);
      if (!db.rvalid) check("data_read_idle", 64'(db.read), 64'd0);
      if (rd_chk && ib.rvalid) begin
        if (iq.size() == 0) check("instr_rvalid_extra", 64'(ib.rvalid), 64'd0);
        else check("instr_read", 64'(ib.read), 64'(iq.pop_front()));
      end
      if (rd_chk && db.rvalid) begin
        if (dq.size() == 0) check("data_rvalid_extra", 64'(db.rvalid), 64'd0);
        else check("data_read", 64'(db.read), 64'(dq.pop_front()));
      end
    end
  end

  // Behavioural main memory with random grant and response delays.
  initial begin : mem_model
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] cur;
    logic        wr;
    logic [3:0]  be;
    forever begin
      step();
      if (mem_auto) begin
        mb.gnt = 1'b0;
        mb.rvalid = 1'b0;
        mb.read = $urandom();
        if (mb.req) begin
          repeat ($urandom_range(0, gdly_max)) step();
          a = mb.adr;
          w = mb.wdata;
          wr = mb.we;
          be = mb.be;
          mb.gnt = 1'b1;
          step();
          mb.gnt = 1'b0;
          repeat ($urandom_range(0, rdly_max)) step();
          cur = store.exists(a) ? store[a] : (a ^ HASH);
          if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = w[8*b +: 8];
            store[a] = cur;
            mb.read = '0;
          end else begin
            mb.read = cur;
          end
          mb.rvalid = 1'b1;
        end
      end
    end
  end

  task automatic instr_agent(input int n);
    logic [31:0] a;
    int k;
    for (int t = 0; t < n; t++) begin
      a = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 2);
      ib.adr = a;
      ib.req = 1'b1;
      iq.push_back(a ^ HASH);
      k = 0;
      do begin @(negedge clk); k++; end while (!ib.gnt && k < 3000);
      if (!ib.gnt) fail("instr_gnt_wait");
      step();
      ib.req = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!ib.rvalid && k < 50);
      if (!ib.rvalid) fail("instr_rvalid_wait");
      step();
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic data_agent(input int n);
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] cur;
    logic [3:0]  be;
    logic        wr;
    int k;
    for (int t = 0; t < n; t++) begin
      a = 32'h2000_0000 + (32'($urandom_range(0, 7)) << 2);
      w = $urandom();
      wr = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(1, 15));
      cur = ref_mem.exists(a) ? ref_mem[a] : (a ^ HASH);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = w[8*b +: 8];
        ref_mem[a] = cur;
        dq.push_back('0);
      end else begin
        dq.push_back(cur);
      end
      db.adr = a;
      db.wdata = w;
      db.we = wr;
      db.be = be;
      db.req = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!db.gnt && k < 3000);
      if (!db.gnt) fail("data_gnt_wait");
      step();
      db.req = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!db.rvalid && k < 50);
      if (!db.rvalid) fail("data_rvalid_wait");
      step();
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    ib.req = 1'b0; ib.we = 1'b0; ib.be = '0; ib.adr = '0; ib.wdata = '0;
    db.req = 1'b0; db.we = 1'b0; db.be = '0; db.adr = '0; db.wdata = '0;
    mb.gnt = 1'b0; mb.rvalid = 1'b0; mb.read = '0;
    #1;
    apply_reset();

    // Both requesters always active, memory always grants.
    gdly_max = 0;
    rdly_max = 0;
    mem_auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_DATA_PRIO_EN
      oq.push_back(OWN_DATA);
`else
      oq.push_back((i % 2 == 0) ? OWN_DATA : OWN_INSTR);
`endif
    end
    own_chk = 1'b1;
    ib.adr = 32'h1000_0040;
    db.adr = 32'h2000_0000;
    ib.req = 1'b1;
    db.req = 1'b1;
    k = 0;
    while (oq.size() != 0 && k < 100) begin @(negedge clk); k++; end
    if (oq.size() != 0) fail("alternate_wait");
    own_chk = 1'b0;
    step();
    ib.req = 1'b0;
    db.req = 1'b0;
    repeat (8) step();
    mem_auto = 1'b0;
    mb.gnt = 1'b0; mb.rvalid = 1'b0; mb.read = 32'h5555_AAAA;
    apply_reset();
    rd_chk = 1'b1;

    // Instruction fetch of 0x100.
    ib.adr = 32'h100;
    ib.req = 1'b1;
    @(negedge clk);
    check("fetch_idle_req", 64'({mb.req, ib.gnt}), 64'd0);
    step();
    mb.gnt = 1'b1;
    @(negedge clk);
    check("fetch_gnt", 64'({ib.gnt, db.gnt, mb.req}), 64'b101);
    check("fetch_adr", 64'(mb.adr), 64'h100);
    step();
    ib.req = 1'b0;
    mb.gnt = 1'b0;
    @(negedge clk);
    check("fetch_resp_wait", 64'({mb.req, ib.rvalid}), 64'd0);
    step();
    mb.rvalid = 1'b1;
    mb.read = 32'hDEAD_BEEF;
    iq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("fetch_rvalid", 64'({ib.rvalid, db.rvalid}), 64'b10);
    check("fetch_data_read", 64'(db.read), 64'd0);
    step();
    mb.rvalid = 1'b0;
    mb.read = 32'h1357_9BDF;

    // Data store of 0x1234 to 0x2004, low half-word.
    db.adr = 32'h2004;
    db.wdata = 32'h1234;
    db.we = 1'b1;
    db.be = 4'b0011;
    db.req = 1'b1;
    step();
    @(negedge clk);
    check("store_fields", {mb.adr, mb.wdata}, {32'h2004, 32'h1234});
    check("store_ctrl", 64'({mb.req, mb.we, mb.be, db.gnt}), 64'b1_1_0011_0);
    step();
    mb.gnt = 1'b1;
    @(negedge clk);
    check("store_gnt", 64'({db.gnt, ib.gnt}), 64'b10);
    step();
    db.req = 1'b0;
    mb.gnt = 1'b0;
    mb.rvalid = 1'b1;
    mb.read = '0;
    dq.push_back('0);
    @(negedge clk);
    check("store_rvalid", 64'(db.rvalid), 64'd1);
    step();
    mb.rvalid = 1'b0;
    @(negedge clk);
    check("store_rvalid_pulse", 64'({db.rvalid, mb.req}), 64'd0);

    // Memory holds off the grant for five cycles.
    ib.adr = 32'h300;
    ib.req = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {mb.adr, 30'd0, mb.req, ib.gnt | db.gnt},
            {32'h300, 32'd2});
      step();
    end
    mb.gnt = 1'b1;
    @(negedge clk);
    check("stall_gnt", 64'(ib.gnt), 64'd1);
    step();
    ib.req = 1'b0;
    mb.gnt = 1'b0;
    mb.rvalid = 1'b1;
    mb.read = 32'hCAFE_0300;
    iq.push_back(32'hCAFE_0300);
    step();
    mb.rvalid = 1'b0;
    apply_reset();

    // Data owner withdraws before the grant; the pointer must not move.
    ib.adr = 32'h400;
    ib.req = 1'b1;
    db.adr = 32'h2008;
    db.we = 1'b0;
    db.req = 1'b1;
    step();
    db.req = 1'b0;
    @(negedge clk);
    check("drop_grant", {mb.adr, 30'd0, mb.req, ib.gnt | db.gnt},
          {32'h2008, 32'd2});
    step();
    db.req = 1'b1;
    @(negedge clk);
    check("drop_to_idle", 64'(mb.req), 64'd0);
    step();
    mb.gnt = 1'b1;
    @(negedge clk);
    check("drop_ptr_kept", 64'({db.gnt, ib.gnt}), 64'b10);
    step();
    db.req = 1'b0;
    mb.gnt = 1'b0;
    mb.rvalid = 1'b1;
    mb.read = 32'h1111_2222;
    dq.push_back(32'h1111_2222);
    step();
    mb.rvalid = 1'b0;

    // Instruction now in flight; reset lands in RESP.
    step();
    mb.gnt = 1'b1;
    @(negedge clk);
    check("rst_pre_gnt", 64'(ib.gnt), 64'd1);
    step();
    ib.req = 1'b0;
    mb.gnt = 1'b0;
    @(negedge clk);
    #2;
    res = 1'b1;
    #1;
    zero_check("rst_resp");
    mb.rvalid = 1'b1;
    mb.read = 32'h0BAD_0BAD;
    #1;
    zero_check("rst_resp_rvalid");
    step();
    res = 1'b0;
    @(negedge clk);
    check("rst_drop", 64'({ib.rvalid, db.rvalid, mb.req}), 64'd0);
    step();
    mb.rvalid = 1'b0;
    @(negedge clk);
    check("rst_idle", 64'(mb.req), 64'd0);

    // Random concurrent traffic.
    step();
    gdly_max = 3;
    rdly_max = 2;
    mem_auto = 1'b1;
    fork
      instr_agent(40);
      data_agent(40);
    join
    repeat (6) step();
    check("sb_drain", 64'(iq.size() + dq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
